// File: rtl/alu_failover_ctrl.sv
// alu_failover_ctrl: selects primary or spare ALU result by voting against a checker ALU.
module alu_failover_ctrl #(
  parameter int WIDTH  = 8,
  parameter int THRESH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VALID,
  input  logic [WIDTH-1:0] RES_A,
  input  logic [WIDTH-1:0] RES_B,
  input  logic [WIDTH-1:0] RES_C,
  input  logic             CLR_FAULT,
  output logic             SEL,
  output logic             FAULT_A,
  output logic             FAULT_ALL,
  output logic             CHK_ERR,
  output logic [7:0]       MISMATCH_CNT,
  output logic [1:0]       STATE
);
  localparam logic [1:0] NORMAL   = 2'd0;
  localparam logic [1:0] SUSPECT  = 2'd1;
  localparam logic [1:0] FAILOVER = 2'd2;
  localparam logic [1:0] FAIL_ALL = 2'd3;
  localparam logic [3:0] TH       = THRESH[3:0];
  logic       eq_ac, eq_bc, eq_ab, good, pri, chk, all_diff;
  logic [1:0] state_nx;
  logic [3:0] streak, streak_nx;
  logic       sel_nx, fault_a_nx, fault_all_nx, chk_nx;
  logic [7:0] cnt_nx;
  assign eq_ac    = RES_A == RES_C;
  assign eq_bc    = RES_B == RES_C;
  assign eq_ab    = RES_A == RES_B;
  assign good     = eq_ac;
  assign pri      = !eq_ac && eq_bc;
  assign chk      = !eq_ac && !eq_bc && eq_ab;
  assign all_diff = !eq_ac && !eq_bc && !eq_ab;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      STATE        <= NORMAL;
      streak       <= '0;
      SEL          <= 1'b1;
      FAULT_A      <= 1'b0;
      FAULT_ALL    <= 1'b0;
      CHK_ERR      <= 1'b0;
      MISMATCH_CNT <= '0;
    end else begin
      STATE        <= state_nx;
      streak       <= streak_nx;
      SEL          <= sel_nx;
      FAULT_A      <= fault_a_nx;
      FAULT_ALL    <= fault_all_nx;
      CHK_ERR      <= chk_nx;
      MISMATCH_CNT <= cnt_nx;
    end
  end
  always_comb begin
    state_nx  = STATE;
    streak_nx = streak;
    if (CLR_FAULT) begin
      state_nx  = NORMAL;
      streak_nx = '0;
    end else if (VALID) begin
      case (STATE)
        NORMAL: begin
          if (pri) begin
            streak_nx = 4'd1;
            state_nx  = (TH == 4'd1) ? FAILOVER : SUSPECT;
          end else if (all_diff) state_nx = FAIL_ALL;
        end
        SUSPECT: begin
          if (good) begin
            state_nx  = NORMAL;
            streak_nx = '0;
          end else if (pri) begin
            streak_nx = streak + 4'd1;
            if (streak + 4'd1 == TH) state_nx = FAILOVER;
          end else if (all_diff) state_nx = FAIL_ALL;
        end
        FAILOVER: if (!eq_bc && !eq_ab) state_nx = FAIL_ALL;
        default: ;
      endcase
    end
  end
  // SEL freezes at whatever it was when FAIL_ALL was entered
  always_comb begin
    sel_nx       = (state_nx == FAILOVER) ? 1'b0 : (state_nx == FAIL_ALL) ? SEL : 1'b1;
    fault_a_nx   = CLR_FAULT ? 1'b0 : (state_nx == FAILOVER) || FAULT_A;
    fault_all_nx = CLR_FAULT ? 1'b0 : (state_nx == FAIL_ALL) || FAULT_ALL;
    chk_nx       = VALID && !CLR_FAULT && chk && (STATE != FAIL_ALL);
    cnt_nx       = (VALID && !eq_ac && MISMATCH_CNT != 8'hFF) ? MISMATCH_CNT + 8'd1 : MISMATCH_CNT;
  end
endmodule

// File: tb/tb_alu_failover_ctrl.sv
// tb_alu_failover_ctrl: directed checks of voting, failover, checker faults and saturation.
module tb_alu_failover_ctrl;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       VALID = 1'b0;
  logic       CLR_FAULT = 1'b0;
  logic [7:0] RES_A = '0, RES_B = '0, RES_C = '0;
  logic       SEL, FAULT_A, FAULT_ALL, CHK_ERR;
  logic [7:0] MISMATCH_CNT;
  logic [1:0] STATE;
  logic [13:0] obs, exp_v;
  int checks = 0;
  int errors = 0;
  alu_failover_ctrl #(.WIDTH(8), .THRESH(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .VALID(VALID), .RES_A(RES_A), .RES_B(RES_B),
    .RES_C(RES_C), .CLR_FAULT(CLR_FAULT), .SEL(SEL), .FAULT_A(FAULT_A),
    .FAULT_ALL(FAULT_ALL), .CHK_ERR(CHK_ERR), .MISMATCH_CNT(MISMATCH_CNT), .STATE(STATE)
  );
  always #5 CLK = ~CLK;
  assign obs = {SEL, FAULT_A, FAULT_ALL, CHK_ERR, STATE, MISMATCH_CNT};
  task automatic step(input logic v, input logic [7:0] a, b, c, input logic clr);
    VALID = v; RES_A = a; RES_B = b; RES_C = c; CLR_FAULT = clr;
    @(posedge CLK); #1;
    VALID = 1'b0; CLR_FAULT = 1'b0;
  endtask
  task automatic do_reset();
    RST_N = 1'b0; VALID = 1'b1; CLR_FAULT = 1'b1; RES_A = 8'h01; RES_B = 8'h02; RES_C = 8'h03;
    @(posedge CLK); #1;
    RST_N = 1'b1; VALID = 1'b0; CLR_FAULT = 1'b0;
  endtask
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset got %h exp %h", obs, exp_v); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL agree[%0d] got %h exp %h", i, obs, exp_v); end
    end
  endtask
  task automatic test_failover();
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fo_pri1 got %h exp %h", obs, exp_v); end
    step(1'b0, 8'h01, 8'h02, 8'h02, 1'b0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fo_gap1 got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd2};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fo_pri2 got %h exp %h", obs, exp_v); end
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd3};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fo_pri3 got %h exp %h", obs, exp_v); end
  endtask
  task automatic test_all_clear();
    step(1'b1, 8'h01, 8'h02, 8'h03, 1'b0);
    exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL all_enter got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h05, 8'h05, 8'h05, 1'b0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL all_ignore got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b1);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd5};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL clear got %h exp %h", obs, exp_v); end
  endtask
  task automatic test_streak_broken();
    do_reset();
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd2};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL brk_pri2 got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h33, 8'h44, 8'h33, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL brk_good got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd3};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL brk_end got %h exp %h", obs, exp_v); end
  endtask
  task automatic test_checker();
    do_reset();
    step(1'b1, 8'h10, 8'h10, 8'h11, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL chk_pulse got %h exp %h", obs, exp_v); end
    step(1'b0, 8'h10, 8'h10, 8'h11, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL chk_drop got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    step(1'b1, 8'h10, 8'h10, 8'h11, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd3};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL chk_suspect got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL chk_hold got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd5};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL chk_failover got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h07, 8'h07, 8'h08, 1'b0);
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'd6};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL chk_in_fo got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h09, 8'h08, 8'h08, 1'b0);
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd7};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fo_stay got %h exp %h", obs, exp_v); end
  endtask
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd255};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL saturate got %h exp %h", obs, exp_v); end
    do_reset();
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_mid got %h exp %h", obs, exp_v); end
    step(1'b1, 8'h01, 8'h02, 8'h02, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL post_reset got %h exp %h", obs, exp_v); end
  endtask
  initial begin
    test_reset();
    test_failover();
    test_all_clear();
    test_streak_broken();
    test_checker();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
